sm_muldiv: RTL and testbench

//  Iterative multiply/divide unit with HI/LO registers for the schoolMIPS core; adds MULT/MULTU/DIV/DIVU/MTHI/MTLO beside sm_alu.

---
 rtl/sm_muldiv_pkg.sv | 40 ++++
 rtl/sm_muldiv_step.sv | 43 ++++
 rtl/sm_muldiv.sv | 191 +++++++++++++++++++
 tb/tb_sm_muldiv.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_muldiv_pkg.sv
// Shared encodings for the schoolMIPS multiply/divide unit: the op codes
// driven by sm_control into sm_muldiv, the R-type funct codes that select
// them, and small decode helpers.
package sm_muldiv_pkg;

    // Multiply/divide unit operation codes (3-bit op port)
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    // op codes 6 and 7 are reserved and ignored by the unit

    // R-type funct codes that sm_control maps onto the unit / HI-LO reads
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1a;
    localparam logic [5:0] F_DIVU  = 6'h1b;

    // Multi-cycle operations (MULT/MULTU/DIV/DIVU) occupy codes 0..3
    function automatic logic md_is_long(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    // Operations whose operands are two's-complement
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    // Operations that run the restoring divider
    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/sm_muldiv_step.sv
// One combinational radix-2 step of the iterative multiply/divide datapath.
// The working pair {rem, q} is shared by both modes:
//   mul: rem = running high half, q = multiplier shifting out / product low
//        half shifting in; step = conditional add of b, then shift right.
//   div: rem = partial remainder, q = dividend shifting out MSB-first /
//        quotient bits shifting in at the LSB; step = restoring subtract.
module sm_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_mode_div,
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    assign w_addend = i_q[0] ? i_b : '0;
    assign w_sum    = {1'b0, i_rem} + {1'b0, w_addend};

    // The partial remainder is always below the divisor, so the trial value
    // fits WIDTH+1 bits and the subtract's MSB is a clean borrow flag.
    assign w_trial  = {i_rem, i_q[WIDTH-1]};
    assign w_diff   = w_trial - {1'b0, i_b};
    assign w_fits   = ~w_diff[WIDTH];

    // Select the shift-add or restoring shift-subtract result
    always_comb begin
        o_rem = w_sum[WIDTH:1];
        o_q   = {w_sum[0], i_q[WIDTH-1:1]};
        if (i_mode_div) begin
            o_rem = w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
            o_q   = {i_q[WIDTH-2:0], w_fits};
        end
    end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers for schoolMIPS.
// Handshake: the unit is idle exactly when ready=1 (busy=~ready); a start
// pulse is taken only in a ready cycle with cancel low, and op/srcA/srcB
// are sampled on that edge only. Long ops raise done for one cycle in the
// FIX state, and HI/LO take the result on the edge that ends that cycle.
// cancel in CALC or FIX drops the op without touching HI/LO, and cancel in
// an idle cycle drops any start (including MTHI/MTLO).
// Operands are converted to magnitudes on entry; signs are reapplied in FIX.
// Valid configurations: WIDTH even and >= 4, UNROLL 1 or 2, and
// WIDTH divisible by 2*UNROLL.
module sm_muldiv
    import sm_muldiv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             cancel,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam int N  = WIDTH / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic             r_is_div;
    logic             r_neg_res;
    logic             r_neg_rem;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_idle_req;
    logic             w_accept_long;
    logic             w_accept_mthi;
    logic             w_accept_mtlo;
    logic             w_commit;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;

    logic [WIDTH-1:0]   w_rem [UNROLL+1];
    logic [WIDTH-1:0]   w_q   [UNROLL+1];
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_signed;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // Request decode in IDLE; cancel suppresses every kind of start
    assign w_idle_req    = (r_state == ST_IDLE) && start && !cancel;
    assign w_accept_long = w_idle_req && md_is_long(op);
    assign w_accept_mthi = w_idle_req && (op == MD_MTHI);
    assign w_accept_mtlo = w_idle_req && (op == MD_MTLO);
    assign w_commit      = (r_state == ST_FIX) && !cancel;

    // Operand magnitudes; unsigned ops never see a negative operand
    assign w_a_neg = md_is_signed(op) && srcA[WIDTH-1];
    assign w_b_neg = md_is_signed(op) && srcB[WIDTH-1];
    assign w_a_mag = w_a_neg ? -srcA : srcA;
    assign w_b_mag = w_b_neg ? -srcB : srcB;

    // Chain of UNROLL radix-2 steps evaluated each CALC cycle
    assign w_rem[0] = r_rem;
    assign w_q[0]   = r_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        sm_muldiv_step #(
            .WIDTH(WIDTH)
        ) u_step (
            .i_mode_div (r_is_div),
            .i_rem      (w_rem[g]),
            .i_q        (w_q[g]),
            .i_b        (r_b),
            .o_rem      (w_rem[g+1]),
            .o_q        (w_q[g+1])
        );
    end

    assign w_prod        = {r_rem, r_q};
    assign w_prod_signed = r_neg_res ? -w_prod : w_prod;

    // Sign correction and divide-by-zero override applied in FIX.
    // With a zero divisor every trial subtract "fits", so the remainder
    // register ends up holding |srcA|; restoring the dividend sign therefore
    // returns srcA unchanged in HI, and LO is forced to all ones.
    always_comb begin
        w_fix_hi = w_prod_signed[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod_signed[WIDTH-1:0];
        if (r_is_div) begin
            w_fix_hi = r_neg_rem ? -r_rem : r_rem;
            w_fix_lo = r_div_zero ? '1 : (r_neg_res ? -r_q : r_q);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: IDLE -> CALC (N cycles) -> FIX -> IDLE, cancel aborts
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept_long) w_state_nxt = ST_CALC;
            ST_CALC: begin
                if (cancel)               w_state_nxt = ST_IDLE;
                else if (r_cnt == '0)     w_state_nxt = ST_FIX;
            end
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch on accept, then one UNROLL-step update per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem      <= '0;
            r_q        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_accept_long) begin
            r_rem      <= '0;
            r_q        <= w_a_mag;
            r_b        <= w_b_mag;
            r_cnt      <= CW'(N - 1);
            r_is_div   <= md_is_div(op);
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_div_zero <= md_is_div(op) && (srcB == '0);
        end else if ((r_state == ST_CALC) && !cancel) begin
            r_rem      <= w_rem[UNROLL];
            r_q        <= w_q[UNROLL];
            r_cnt      <= r_cnt - CW'(1);
        end
    end

    // HI/LO: result commit from FIX, or direct MTHI/MTLO writes from IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end else begin
            if (w_accept_mthi) r_hi <= srcA;
            if (w_accept_mtlo) r_lo <= srcA;
        end
    end

    assign ready       = (r_state == ST_IDLE);
    assign busy        = ~ready;
    assign done        = w_commit;
    assign divZero     = w_commit && r_div_zero;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sm_muldiv.sv
// Bench for sm_muldiv: two instances (UNROLL=1 and UNROLL=2) share all
// inputs. Table vectors and random ops are checked against a plain
// 64-bit arithmetic model; hand sequences cover cancel, reset, MTHI/MTLO
// and ignored starts.
`timescale 1ns/1ps
module tb_sm_muldiv;
  import sm_muldiv_pkg::*;

  localparam int W    = 32;
  localparam int LAT1 = W / 1 + 1;
  localparam int LAT2 = W / 2 + 1;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dz;
  } vec_t;

  // ---------------- clock / reset / DUTs ----------------
  logic         clk;
  logic         rst;
  logic         start;
  logic         cancel;
  logic [2:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;

  logic         ready1, busy1, done1, dz1;
  logic [W-1:0] hi1, lo1;
  logic [1:0]   st1;
  logic         ready2, busy2, done2, dz2;
  logic [W-1:0] hi2, lo2;
  logic [1:0]   st2;

  int n_vec = 0;
  int n_err = 0;
  logic [2*W:0] exp_q1[$];
  logic [2*W:0] exp_q2[$];
  vec_t tbl [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sm_muldiv #(.WIDTH(W), .UNROLL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .srcA(src_a), .srcB(src_b),
    .cancel(cancel), .ready(ready1), .busy(busy1), .done(done1),
    .divZero(dz1), .hi(hi1), .lo(lo1), .o_dbg_state(st1)
  );

  sm_muldiv #(.WIDTH(W), .UNROLL(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .srcA(src_a), .srcB(src_b),
    .cancel(cancel), .ready(ready2), .busy(busy2), .done(done2),
    .divZero(dz2), .hi(hi2), .lo(lo2), .o_dbg_state(st2)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {divZero, hi, lo} from plain 64-bit arithmetic
  function automatic logic [2*W:0] ref_model(input logic [2:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic [W-1:0]    q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    ref_model = '0;
    case (o)
      MD_MULT:  begin p = 64'(sa * sb); ref_model = {1'b0, p}; end
      MD_MULTU: begin p = ua * ub;      ref_model = {1'b0, p}; end
      MD_DIV: begin
        if (b == '0) ref_model = {1'b1, a, 32'hFFFF_FFFF};
        else begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
          ref_model = {1'b0, r, q};
        end
      end
      MD_DIVU: begin
        if (b == '0) ref_model = {1'b1, a, 32'hFFFF_FFFF};
        else begin
          q = 32'(ua / ub);
          r = 32'(ua % ub);
          ref_model = {1'b0, r, q};
        end
      end
      default: ref_model = '0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Present a start for one cycle; returns just after the accepting edge
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom_range(0, 7));
    src_a = $urandom;
    src_b = $urandom;
  endtask

  // Single-cycle MTHI/MTLO (or any short request)
  task automatic mt(input logic [2:0] o, input logic [W-1:0] d);
    @(negedge clk);
    op = o; src_a = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Follow both DUTs after an issue: latency, divZero with done, HI/LO on
  // the following edge. inject_at>0 drives an MTHI start while busy.
  task automatic wait_results(input string tag, input int inject_at, input logic [W-1:0] hold_hi);
    int           edges;
    bit           got1, got2, pend1, pend2;
    logic         dzs1, dzs2;
    logic [2*W:0] e;
    edges = 1;
    got1 = 0; got2 = 0; pend1 = 0; pend2 = 0;
    dzs1 = 0; dzs2 = 0;
    while (((!got1 || !got2) || pend1 || pend2) && edges < 60) begin
      @(posedge clk);
      edges++;
      #1;
      if (start) begin
        start = 1'b0;
        check({tag, " busy after ignored start"}, (2*W+1)'({busy1, busy2}), (2*W+1)'(2'b11));
        check({tag, " hi after ignored MTHI"}, (2*W+1)'(hi1), (2*W+1)'(hold_hi));
      end
      if (pend1) begin
        e = exp_q1.pop_front();
        check({tag, " u1 dz/hi/lo"}, {dzs1, hi1, lo1}, e);
        check({tag, " u1 done/ready after"}, (2*W+1)'({done1, ready1}), (2*W+1)'(2'b01));
        pend1 = 0;
      end
      if (pend2) begin
        e = exp_q2.pop_front();
        check({tag, " u2 dz/hi/lo"}, {dzs2, hi2, lo2}, e);
        check({tag, " u2 done/ready after"}, (2*W+1)'({done2, ready2}), (2*W+1)'(2'b01));
        pend2 = 0;
      end
      if (done1 && !got1) begin
        got1 = 1; pend1 = 1; dzs1 = dz1;
        check({tag, " u1 latency"}, (2*W+1)'(edges), (2*W+1)'(LAT1));
      end
      if (done2 && !got2) begin
        got2 = 1; pend2 = 1; dzs2 = dz2;
        check({tag, " u2 latency"}, (2*W+1)'(edges), (2*W+1)'(LAT2));
      end
      if (inject_at != 0 && edges == inject_at) begin
        op = MD_MTHI; src_a = 32'h0000_1234; start = 1'b1;
      end
    end
    if (!got1 || pend1) begin
      check({tag, " u1 done timeout"}, (2*W+1)'(0), (2*W+1)'(1));
      if (exp_q1.size() > 0) e = exp_q1.pop_front();
    end
    if (!got2 || pend2) begin
      check({tag, " u2 done timeout"}, (2*W+1)'(0), (2*W+1)'(1));
      if (exp_q2.size() > 0) e = exp_q2.pop_front();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2*W:0] e;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    int           ndone;

    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; src_a = '0; src_b = '0;

    tbl[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[1] = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    tbl[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3] = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    tbl[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    tbl[5] = '{MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    tbl[6] = '{MD_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    tbl[7] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset u1 hi/lo", (2*W+1)'({hi1, lo1}), '0);
    check("reset u1 flags", (2*W+1)'({ready1, busy1, done1, dz1}), (2*W+1)'(4'b1000));
    check("reset u2 flags", (2*W+1)'({ready2, busy2, done2, dz2, hi2, lo2}), (2*W+1)'({4'b1000, 64'h0}));
    @(negedge clk);
    rst = 1'b0;

    // Table vectors on both unroll settings
    for (int i = 0; i < 8; i++) begin
      exp_q1.push_back({tbl[i].exp_dz, tbl[i].exp_hi, tbl[i].exp_lo});
      exp_q2.push_back({tbl[i].exp_dz, tbl[i].exp_hi, tbl[i].exp_lo});
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_results($sformatf("vec%0d", i), 0, '0);
    end

    // Random ops against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = 32'($urandom);
      endcase
      e = ref_model(ro, ra, rb);
      exp_q1.push_back(e);
      exp_q2.push_back(e);
      issue(ro, ra, rb);
      wait_results($sformatf("rand%0d", i), 0, '0);
    end

    // Cancel during CALC: no done, HI/LO keep preloaded values
    mt(MD_MTHI, 32'h0000_AAAA);
    mt(MD_MTLO, 32'h0000_5555);
    check("preload hi/lo", (2*W+1)'({hi1, lo1}), (2*W+1)'({32'h0000_AAAA, 32'h0000_5555}));
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    #1;
    check("cancel calc busy", (2*W+1)'({busy1, done1, busy2, done2}), (2*W+1)'(4'b1010));
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("cancel calc ready", (2*W+1)'({ready1, ready2}), (2*W+1)'(2'b11));
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      ndone += int'(done1) + int'(done2);
    end
    check("cancel calc no done", (2*W+1)'(ndone), '0);
    check("cancel calc u1 hi/lo", (2*W+1)'({hi1, lo1}), (2*W+1)'({32'h0000_AAAA, 32'h0000_5555}));
    check("cancel calc u2 hi/lo", (2*W+1)'({hi2, lo2}), (2*W+1)'({32'h0000_AAAA, 32'h0000_5555}));

    // start+cancel in IDLE: MTHI and a long op both dropped
    @(negedge clk);
    op = MD_MTHI; src_a = 32'hDEAD_BEEF; start = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    check("start+cancel MTHI", (2*W+1)'({ready1, hi1}), (2*W+1)'({1'b1, 32'h0000_AAAA}));
    @(negedge clk);
    op = MD_DIV; src_a = 32'd9; src_b = 32'd3; start = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    check("start+cancel DIV", (2*W+1)'({ready1, ready2}), (2*W+1)'(2'b11));

    // Reserved op codes are ignored
    mt(3'd6, 32'hFFFF_0000);
    mt(3'd7, 32'hFFFF_0000);
    check("reserved ops", (2*W+1)'({ready1, done1, hi1, lo1}),
          (2*W+1)'({2'b10, 32'h0000_AAAA, 32'h0000_5555}));

    // start (MTHI) while busy is ignored; operands changing mid-op are not sampled
    e = ref_model(MD_DIVU, 32'd1000, 32'd3);
    exp_q1.push_back(e);
    exp_q2.push_back(e);
    issue(MD_DIVU, 32'd1000, 32'd3);
    wait_results("start-in-calc", 4, 32'h0000_AAAA);

    // MTHI from IDLE writes hi on the next edge without done
    mt(MD_MTHI, 32'h0000_1234);
    check("MTHI idle", (2*W+1)'({done1, ready1, hi1, lo1}), (2*W+1)'({2'b01, 32'h0000_1234, 32'd333}));

    // cancel in the FIX cycle beats done on the UNROLL=1 instance
    mt(MD_MTHI, 32'h0000_0BAD);
    mt(MD_MTLO, 32'h0000_0F00);
    issue(MD_MULTU, 32'd3, 32'd5);
    repeat (LAT1 - 1) @(posedge clk);
    #1;
    check("fix done before cancel", (2*W+1)'(done1), (2*W+1)'(1));
    cancel = 1'b1;
    #1;
    check("fix done under cancel", (2*W+1)'({done1, dz1}), '0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    check("fix cancel u1 hi/lo", (2*W+1)'({ready1, hi1, lo1}), (2*W+1)'({1'b1, 32'h0000_0BAD, 32'h0000_0F00}));
    check("fix cancel u2 result", (2*W+1)'({hi2, lo2}), (2*W+1)'({32'd0, 32'd15}));

    // Asynchronous reset mid-CALC clears HI/LO and returns to IDLE at once
    issue(MD_MULT, 32'd7, 32'd9);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst mid-calc u1", (2*W+1)'({ready1, busy1, hi1, lo1}), (2*W+1)'({2'b10, 64'h0}));
    check("rst mid-calc u2", (2*W+1)'({ready2, busy2, hi2, lo2}), (2*W+1)'({2'b10, 64'h0}));
    @(negedge clk);
    rst = 1'b0;

    // Normal op after reset recovery
    e = ref_model(MD_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFB);
    exp_q1.push_back(e);
    exp_q2.push_back(e);
    issue(MD_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFB);
    wait_results("after-rst", 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
